bp_cce_ucode_loader: RTL
========================

// Module: bp_cce_ucode_loader
// PURPOSE
// - Upstream feeder of the CCE instruction RAM's ucode programming port (ucode_v/w/addr/data).
// - Accepts a ready/valid stream of microcode words and writes them to RAM addresses 0..len-1.
// - Reads the image back and checks it against a rotate-XOR checksum accumulated during the write.
// - Runs while the CCE is in INIT/uncached mode; it must reach done before cce_mode goes normal.
// PARAMETERS
// - cce_instr_width_p        48   microcode word width
// - cce_pc_width_p           8    RAM address width
// - num_cce_instr_ram_els_p  256  RAM depth; must be <= 2**cce_pc_width_p
// PORTS
// - clk_i               in   1      clock
// - reset_i             in   1      asynchronous, active-high reset
// - start_i             in   1      begin a load; sampled only in IDLE, DONE or ERROR
// - len_i               in   PW+1   word count, PW=cce_pc_width_p; sampled with start_i
// - data_v_i            in   1      stream word valid
// - data_i              in   IW     stream word, IW=cce_instr_width_p
// - data_ready_and_o    out  1      stream ready; high only in WRITE
// - ram_v_o             out  1      to RAM ucode_v_i
// - ram_w_o             out  1      to RAM ucode_w_i
// - ram_addr_o          out  PW     to RAM ucode_addr_i
// - ram_data_o          out  IW     to RAM ucode_data_i
// - ram_data_i          in   IW     from RAM ucode_data_o; synchronous read, 1-cycle latency
// - busy_o / done_o / error_o  out  1  status outputs, all registered
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; counters, checksums, busy_o, done_o, error_o = 0.
//   RAM contents are undefined after a mid-load reset.
// - The ram_* outputs are combinational from state and counters. ram_v_o=0 outside WRITE/VREAD.
// - IDLE/DONE/ERROR + start_i:
//   - len_i==0: DONE next cycle; no RAM access; done_o=1.
//   - len_i > num_cce_instr_ram_els_p: ERROR next cycle; error_o=1.
//   - Otherwise: clear cnt, wsum and rsum; latch len; go to WRITE. done_o and error_o drop.
// - WRITE: data_ready_and_o=1.
//   - On data_v_i: ram_v_o=ram_w_o=1, ram_addr_o=cnt, ram_data_o=data_i.
//   - Same handshake: wsum <= rotl1(wsum)^data_i, and cnt++.
//   - On the beat where cnt==len-1: cnt<=0 and go to VREAD.
//   - A bubble (data_v_i=0) causes no write and no state change.
// - VREAD: ram_v_o=1, ram_w_o=0, ram_addr_o=cnt; one read per cycle, no stall.
//   - Each cycle from the second VREAD cycle on: rsum <= rotl1(rsum)^ram_data_i.
//   - After issuing address len-1, go to VCHK.
// - VCHK: fold the last read word into rsum.
//   - If the final rsum equals wsum: DONE. Otherwise: ERROR.
// - Timing: if the last write is at cycle T, reads occur at T+1..T+len.
//   done_o or error_o is high from T+len+2.
// - busy_o=1 in WRITE, VREAD and VCHK.
// - done_o and error_o are sticky until the next accepted start_i. They are never both 1.
// - start_i while busy is ignored. Data beats outside WRITE are not accepted.
// - Checksum arithmetic: IW bits, rotl1(x)={x[IW-2:0],x[IW-1]}. Ordered, so swapped words are detected.
// - cnt width is PW+1, so len == 2**PW does not wrap.
// - Illegal state encoding: IDLE next cycle.
// STRUCTURE
// - bp_cce_pkg: bp_cce_ucode_loader_state_e {IDLE, WRITE, VREAD, VCHK, DONE, ERROR} (logic [2:0]).
// - bp_cce_pkg: function bp_cce_ucode_csum(old, word) returning rotl1(old)^word.
// - No sub-module. One FSM plus cnt/len/wsum/rsum registers.
// - Instantiated beside the instruction RAM. When busy_o=1 its ram_* outputs own the ucode port.
// TESTING
// - Load len=4 with words 1,2,3,4 and data_v_i held high.
//   -> Writes to addresses 0..3 on consecutive cycles, then 4 reads.
//   -> done_o=1 exactly 6 cycles after the last write; error_o=0.
// - Same load with data_v_i toggling 1,0,1,0.
//   -> Writes occur only on handshake cycles; addresses stay contiguous 0..3; done_o=1.
// - Load len=3, and the bench RAM model flips bit 0 of address 1 before VREAD -> error_o=1, done_o=0.
// - Load len=0 -> done_o=1 next cycle with zero ram_v_o cycles.
// - Load len=257 -> error_o=1 next cycle with zero RAM accesses.
// - Load len=256 -> all 256 writes and reads complete, done_o=1.
// - Assert reset_i after 2 of 4 beats.
//   -> busy_o, done_o, error_o and ram_v_o drop to 0 immediately (asynchronously).
//   -> A restarted load with len=2 completes with done_o=1.
// - Pulse start_i during VREAD -> ignored; the current load finishes normally.

Source files
------------

// File: rtl/bp_cce_pkg.sv
// Shared types and helpers for the CCE microcode loader.
//   bp_cce_ucode_loader_state_e : loader FSM encoding
//   bp_cce_ucode_csum           : ordered rotate-XOR checksum step
package bp_cce_pkg;

    localparam int unsigned bp_cce_instr_width_gp = 48;
    localparam int unsigned bp_cce_pc_width_gp    = 8;
    localparam int unsigned bp_cce_ram_els_gp     = 256;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        VREAD = 3'd2,
        VCHK  = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } bp_cce_ucode_loader_state_e;

    // Rotate left by one, then fold in the new word; the rotate makes the sum order-sensitive.
    function automatic logic [bp_cce_instr_width_gp-1:0] bp_cce_ucode_csum(
        input logic [bp_cce_instr_width_gp-1:0] old_sum,
        input logic [bp_cce_instr_width_gp-1:0] word
    );
        return {old_sum[bp_cce_instr_width_gp-2:0], old_sum[bp_cce_instr_width_gp-1]} ^ word;
    endfunction

endpackage

// File: rtl/bp_cce_ucode_loader_if.sv
// Stream-in and RAM ucode-port bundle of the microcode loader.
// Signal suffixes are named from the loader's point of view.
//   data_v_i / data_i / data_ready_and_o : ready/valid microcode word stream
//   ram_v_o / ram_w_o / ram_addr_o / ram_data_o : request to the RAM ucode port
//   ram_data_i                           : RAM read data, one-cycle latency
// master = loader side, slave = stream source plus instruction RAM.
interface bp_cce_ucode_loader_if #(
    parameter int unsigned iw_p = 48,
    parameter int unsigned pw_p = 8
) ();

    logic            data_v_i;
    logic [iw_p-1:0] data_i;
    logic            data_ready_and_o;

    logic            ram_v_o;
    logic            ram_w_o;
    logic [pw_p-1:0] ram_addr_o;
    logic [iw_p-1:0] ram_data_o;
    logic [iw_p-1:0] ram_data_i;

    modport master (
        input  data_v_i,
        input  data_i,
        output data_ready_and_o,
        output ram_v_o,
        output ram_w_o,
        output ram_addr_o,
        output ram_data_o,
        input  ram_data_i
    );

    modport slave (
        output data_v_i,
        output data_i,
        input  data_ready_and_o,
        input  ram_v_o,
        input  ram_w_o,
        input  ram_addr_o,
        input  ram_data_o,
        output ram_data_i
    );

endinterface

// File: rtl/bp_cce_ucode_loader.sv
// Microcode loader for the CCE instruction RAM. Writes a streamed image to
// addresses 0..len-1, reads it back and compares a rotate-XOR checksum of the
// read-back against the one accumulated during the write.
// Ports:
//   clk_i, reset_i   clock, asynchronous active-high reset
//   start_i, len_i   start a load of len_i words (sampled in IDLE/DONE/ERROR)
//   io               stream + RAM ucode port bundle (master side)
//   busy_o           load in progress (WRITE/VREAD/VCHK), registered
//   done_o, error_o  sticky result of the last load, registered
// The ram_* and data_ready_and_o outputs are combinational from state and counters.
module bp_cce_ucode_loader
    import bp_cce_pkg::*;
#(
    parameter int unsigned cce_instr_width_p       = bp_cce_instr_width_gp,
    parameter int unsigned cce_pc_width_p          = bp_cce_pc_width_gp,
    parameter int unsigned num_cce_instr_ram_els_p = bp_cce_ram_els_gp
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic [cce_pc_width_p:0] len_i,
    bp_cce_ucode_loader_if.master   io,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o
);

    localparam int unsigned IW = cce_instr_width_p;
    localparam int unsigned PW = cce_pc_width_p;
    // One extra bit so a full-depth image (len == 2**PW) does not wrap.
    localparam int unsigned CW = cce_pc_width_p + 1;

    bp_cce_ucode_loader_state_e state_q, state_d;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] len_q, len_d;
    logic [IW-1:0] wsum_q, wsum_d;
    logic [IW-1:0] rsum_q, rsum_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic          last_c;
    logic [IW-1:0] rsum_next_c;

    assign last_c      = (cnt_q == (len_q - CW'(1)));
    assign rsum_next_c = bp_cce_ucode_csum(rsum_q, io.ram_data_i);

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            wsum_q  <= '0;
            rsum_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            wsum_q  <= wsum_d;
            rsum_q  <= rsum_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    // Next-state, datapath updates and RAM port drive.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        wsum_d  = wsum_q;
        rsum_d  = rsum_q;
        done_d  = done_q;
        error_d = error_q;

        io.data_ready_and_o = 1'b0;
        io.ram_v_o          = 1'b0;
        io.ram_w_o          = 1'b0;
        io.ram_addr_o       = cnt_q[PW-1:0];
        io.ram_data_o       = io.data_i;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        error_d = 1'b0;
                    end else if (len_i > CW'(num_cce_instr_ram_els_p)) begin
                        state_d = ERROR;
                        done_d  = 1'b0;
                        error_d = 1'b1;
                    end else begin
                        state_d = WRITE;
                        cnt_d   = '0;
                        len_d   = len_i;
                        wsum_d  = '0;
                        rsum_d  = '0;
                        done_d  = 1'b0;
                        error_d = 1'b0;
                    end
                end
            end

            WRITE: begin
                io.data_ready_and_o = 1'b1;
                if (io.data_v_i) begin
                    io.ram_v_o = 1'b1;
                    io.ram_w_o = 1'b1;
                    wsum_d     = bp_cce_ucode_csum(wsum_q, io.data_i);
                    if (last_c) begin
                        cnt_d   = '0;
                        state_d = VREAD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            VREAD: begin
                io.ram_v_o = 1'b1;
                // Read data lags the address by one cycle, so the first VREAD cycle has nothing to fold.
                if (cnt_q != '0) begin
                    rsum_d = rsum_next_c;
                end
                if (last_c) begin
                    cnt_d   = '0;
                    state_d = VCHK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            VCHK: begin
                rsum_d = rsum_next_c;
                if (rsum_next_c == wsum_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ERROR;
                    error_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == WRITE) || (state_d == VREAD) || (state_d == VCHK);
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign error_o = error_q;

endmodule
